uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte requesters, e.g. the row/ack feedback path, error reporting and status/debug sources.
- Each requested byte is granted round-robin, launched with a one-cycle start strobe, and tracked through the transmitter busy window.
- A configurable inter-byte gap is enforced after every byte.
- Sits between the requesting controllers and the uart_transmiter start_strobe/data/busy interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width to the transmitter.
- GAP_CYCLES, 16, idle clocks enforced after each byte before the next arbitration; 0 allowed.
- START_TIMEOUT, 64, clocks to wait for tx_busy to rise after a launch before flagging an error (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  NUM_REQ  per-requester byte request level
- req_data  in  NUM_REQ*DATA_W  byte of requester i at [DATA_W*i +: DATA_W]
- gnt  out  NUM_REQ  one-hot one-cycle pulse: byte of requester i accepted
- done  out  NUM_REQ  one-hot one-cycle pulse: byte of requester i fully shifted out
- tx_start  out  1  one-cycle start strobe to transmitter
- tx_data  out  DATA_W  latched byte to transmitter, held until next grant
- tx_busy  in  1  transmitter busy
- active_id  out  $clog2(NUM_REQ)  index of last granted requester
- arb_busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse: busy never rose after launch

Behaviour:
- Reset: async assert forces state IDLE; outputs become gnt=0, done=0, tx_start=0, tx_data=0, active_id=0, arb_busy=0, timeout_err=0. Internal state resets to last_id=NUM_REQ-1 (req0 wins first) and both counters=0.
- All outputs are registered.
- States: IDLE, WAIT_HI, WAIT_LO, GAP.
- IDLE: arbitrates only when |req==1 and tx_busy==0.
  - Winner i is the first set bit searching from (last_id+1) mod NUM_REQ upward, with wrap.
  - On that edge: tx_data<=req_data[i], tx_start<=1, gnt[i]<=1, active_id<=i, last_id<=i, cnt<=0, state<=WAIT_HI.
  - If tx_busy==1 in IDLE (e.g. after reset mid-byte), arbitration stalls until tx_busy is low.
- Latency: req sampled high at edge N with arbiter IDLE and tx_busy low -> gnt and tx_start high during cycle N..N+1, low from edge N+1.
- WAIT_HI: cnt increments each clock.
  - tx_busy==1 -> WAIT_LO.
  - Else cnt==START_TIMEOUT-1 -> timeout_err pulse, no done, state<=GAP.
- WAIT_LO: tx_busy==0 sampled -> done[active_id] pulse, cnt<=0, state<=GAP.
- GAP: GAP_CYCLES==0 -> IDLE on the next edge. Else count GAP_CYCLES clocks, then IDLE. No arbitration during GAP.
- Minimum spacing between tx_start pulses = transmit time + GAP_CYCLES + 2 clocks.
- Requester contract:
  - Hold req high and req_data stable until gnt is seen.
  - Drop req in the gnt cycle or earlier.
  - req still high when IDLE is next re-entered is a new request.
  - Deasserting req before gnt withdraws the request with no side effects.
  - req_data is sampled only on the grant edge.
- Simultaneous requests: exactly one gnt per launch; gnt and done are never multi-hot.
- A requester holding req continuously gets at most one byte per full rotation while others request (fairness).
- tx_busy glitch high in IDLE only delays arbitration.
- tx_busy falling in WAIT_HI cannot occur legally; it is ignored.
- arb_busy = (state != IDLE).

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hAA, transmitter model busy for 100 clocks -> gnt[0] and tx_start 1 clk later with tx_data=8'hAA; done[0] one clk after busy falls; arb_busy low 16 clks after done.
- All four requesting simultaneously from reset (data 8'h11, 8'h22, 8'h33, 8'hFF), each dropped on its gnt -> grant order 0,1,2,3; tx_start spacing = busy time + 18 clks; done order 0,1,2,3.
- Fairness: req0 held high permanently, req2 asserted after first byte -> grants alternate 0,2,0,2; req1/req3 never granted.
- Timeout: tx_busy tied 0, req=4'b0100 -> tx_start once, timeout_err pulse 63 clks after the WAIT_HI entry edge, no done; next arbitration after the 16-clk gap re-grants requester 2 if req2 still high.
- Reset mid-operation: assert rst_n=0 during WAIT_LO with tx_busy held 1, release -> all outputs 0 immediately (async); no grant until tx_busy falls; first grant goes to lowest set req bit starting at 0.
- GAP_CYCLES=0 build, two back-to-back requesters -> second tx_start exactly 2 clks after the first byte's done pulse edge.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Each grant launches one byte, follows the busy window, then enforces an idle gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       arb_busy,
    output logic                       timeout_err
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
    logic [ID_W-1:0]     last_id_reg, last_id_next;
    logic [ID_W-1:0]     active_id_reg, active_id_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]  done_reg, done_next;
    logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
    logic                tx_start_reg, tx_start_next;
    logic                timeout_reg, timeout_next;
    logic                arb_busy_reg, arb_busy_next;

    logic [DATA_W-1:0]   req_bytes [NUM_REQ];
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    int                  cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[DATA_W*gi +: DATA_W];
        end
    endgenerate

    // Search upward from the requester after the last winner, wrapping once.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(last_id_reg) + 1 + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_id_next   = last_id_reg;
        active_id_next = active_id_reg;
        tx_data_next   = tx_data_reg;
        gnt_next       = '0;
        done_next      = '0;
        tx_start_next  = 1'b0;
        timeout_next   = 1'b0;
        cnt_inc        = cnt_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                if (win_found && !tx_busy) begin
                    tx_data_next     = req_bytes[win_id];
                    tx_start_next    = 1'b1;
                    gnt_next[win_id] = 1'b1;
                    active_id_next   = win_id;
                    last_id_next     = win_id;
                    cnt_next         = '0;
                    state_next       = WAIT_HI;
                end
            end
            WAIT_HI: begin
                cnt_next = cnt_inc;
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (cnt_inc == CNT_W'(START_TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = GAP;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    done_next[active_id_reg] = 1'b1;
                    cnt_next                 = '0;
                    state_next               = GAP;
                end
            end
            GAP: begin
                // cnt_inc counts gap clocks elapsed including this one.
                cnt_next = cnt_inc;
                if (GAP_CYCLES == 0 || cnt_inc == CNT_W'(GAP_CYCLES)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        arb_busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            last_id_reg   <= ID_W'(NUM_REQ - 1);
            active_id_reg <= '0;
            tx_data_reg   <= '0;
            gnt_reg       <= '0;
            done_reg      <= '0;
            tx_start_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            arb_busy_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_id_reg   <= last_id_next;
            active_id_reg <= active_id_next;
            tx_data_reg   <= tx_data_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            tx_start_reg  <= tx_start_next;
            timeout_reg   <= timeout_next;
            arb_busy_reg  <= arb_busy_next;
        end
    end

    assign gnt         = gnt_reg;
    assign done        = done_reg;
    assign tx_start    = tx_start_reg;
    assign tx_data     = tx_data_reg;
    assign active_id   = active_id_reg;
    assign arb_busy    = arb_busy_reg;
    assign timeout_err = timeout_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a default-gap instance plus a zero-gap instance,
// each driving a simple busy-window transmitter model.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0, gnt, done;
    logic [N*W-1:0] req_data = '0;
    logic           tx_start, tx_busy, arb_busy, timeout_err;
    logic [W-1:0]   tx_data;
    logic [1:0]     active_id;

    logic [N-1:0]   req_z = '0, gnt_z, done_z;
    logic [N*W-1:0] req_data_z = '0;
    logic           tx_start_z, tx_busy_z, arb_busy_z, timeout_err_z;
    logic [W-1:0]   tx_data_z;
    logic [1:0]     active_id_z;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int multi_hot = 0;

    logic model_en = 1'b1, model_busy = 1'b0, force_busy = 1'b0, model_busy_z = 1'b0;
    int   busy_len = 20, model_cnt = 0, model_cnt_z = 0;
    logic [N-1:0] drop_mask = '0, drop_mask_z = '0;

    int         gnt_ids[$], gnt_cyc[$], done_ids[$], done_cyc[$], to_cyc[$], start_cyc[$];
    logic [7:0] start_data[$];
    int         z_gnt_ids[$], z_start_cyc[$], z_done_cyc[$];

    assign tx_busy   = model_busy | force_busy;
    assign tx_busy_z = model_busy_z;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(16), .START_TIMEOUT(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .active_id(active_id),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(0), .START_TIMEOUT(64)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .req(req_z), .req_data(req_data_z), .gnt(gnt_z), .done(done_z),
        .tx_start(tx_start_z), .tx_data(tx_data_z), .tx_busy(tx_busy_z), .active_id(active_id_z),
        .arb_busy(arb_busy_z), .timeout_err(timeout_err_z)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int oh_id(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock: observe outputs just after the edge, log events, run transmitter models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if ($countones(gnt) > 1 || $countones(done) > 1 ||
            $countones(gnt_z) > 1 || $countones(done_z) > 1) multi_hot++;
        if (gnt != '0) begin
            gnt_ids.push_back(oh_id(gnt));
            gnt_cyc.push_back(cyc);
            req = req & ~(gnt & drop_mask);
        end
        if (tx_start) begin
            start_cyc.push_back(cyc);
            start_data.push_back(tx_data);
        end
        if (done != '0) begin
            done_ids.push_back(oh_id(done));
            done_cyc.push_back(cyc);
        end
        if (timeout_err) to_cyc.push_back(cyc);
        if (gnt_z != '0) begin
            z_gnt_ids.push_back(oh_id(gnt_z));
            req_z = req_z & ~(gnt_z & drop_mask_z);
        end
        if (tx_start_z) z_start_cyc.push_back(cyc);
        if (done_z != '0) z_done_cyc.push_back(cyc);

        if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) model_busy = 1'b0;
        end
        if (tx_start && model_en) begin
            model_busy = 1'b1;
            model_cnt  = busy_len;
        end
        if (model_cnt_z > 0) begin
            model_cnt_z--;
            if (model_cnt_z == 0) model_busy_z = 1'b0;
        end
        if (tx_start_z) begin
            model_busy_z = 1'b1;
            model_cnt_z  = busy_len;
        end
    endtask

    task automatic clear_logs();
        gnt_ids.delete(); gnt_cyc.delete(); done_ids.delete(); done_cyc.delete();
        to_cyc.delete(); start_cyc.delete(); start_data.delete();
        z_gnt_ids.delete(); z_start_cyc.delete(); z_done_cyc.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        model_busy = 1'b0; model_cnt = 0; model_busy_z = 1'b0; model_cnt_z = 0;
        force_busy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int n = 0; n < limit; n++) begin
            if (req == '0 && req_z == '0 && !arb_busy && !arb_busy_z) break;
            step();
        end
        check(tag, arb_busy, 0);
    endtask

    logic [7:0] exp4 [4] = '{8'h11, 8'h22, 8'h33, 8'hFF};
    int fair_exp [4] = '{0, 2, 0, 2};

    initial begin
        // Reset values with requests pending
        req = 4'b1111;
        for (int i = 0; i < 3; i++) step();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_active_id", active_id, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_timeout", timeout_err, 0);
        req = '0;
        rst_n = 1'b1;
        step();

        // Single request, 100-clock byte
        clear_logs();
        busy_len = 100;
        drop_mask = '1;
        req_data[7:0] = 8'hAA;
        req = 4'b0001;
        step();
        check("single_gnt", gnt, 4'b0001);
        check("single_tx_start", tx_start, 1);
        check("single_tx_data", tx_data, 8'hAA);
        check("single_active_id", active_id, 0);
        check("single_arb_busy", arb_busy, 1);
        step();
        check("single_gnt_pulse", gnt, 0);
        check("single_start_pulse", tx_start, 0);
        for (int n = 0; n < 300 && done_ids.size() < 1; n++) step();
        check("single_done_seen", done_ids.size(), 1);
        if (done_ids.size() == 1 && start_cyc.size() == 1) begin
            check("single_done_id", done_ids[0], 0);
            check("single_done_lat", done_cyc[0] - start_cyc[0], busy_len + 1);
            check("single_data_held", tx_data, 8'hAA);
            for (int n = 0; n < 40 && arb_busy; n++) step();
            check("single_gap_len", cyc - done_cyc[0], 16);
        end

        // Four simultaneous requests from reset
        reset_dut();
        clear_logs();
        busy_len = 20;
        req_data = {8'hFF, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int n = 0; n < 400 && done_ids.size() < 4; n++) step();
        check("all4_gnt_count", gnt_ids.size(), 4);
        check("all4_done_count", done_ids.size(), 4);
        if (gnt_ids.size() == 4 && done_ids.size() == 4 && start_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("all4_gnt_order%0d", i), gnt_ids[i], i);
                check($sformatf("all4_data%0d", i), start_data[i], exp4[i]);
                check($sformatf("all4_done_order%0d", i), done_ids[i], i);
                if (i > 0) check($sformatf("all4_spacing%0d", i),
                                 start_cyc[i] - start_cyc[i-1], busy_len + 18);
            end
        end
        wait_idle("all4_idle", 100);

        // Fairness: req0 held, req2 joins after the first byte
        clear_logs();
        drop_mask = 4'b1010;
        req = 4'b0001;
        for (int n = 0; n < 50 && gnt_ids.size() < 1; n++) step();
        req[2] = 1'b1;
        for (int n = 0; n < 400 && gnt_ids.size() < 4; n++) step();
        req = '0;
        check("fair_count", gnt_ids.size(), 4);
        if (gnt_ids.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("fair_order%0d", i), gnt_ids[i], fair_exp[i]);
        wait_idle("fair_idle", 200);

        // Timeout: transmitter never goes busy, req2 held
        clear_logs();
        model_en = 1'b0;
        drop_mask = '0;
        req_data[23:16] = 8'h5C;
        req = 4'b0100;
        for (int n = 0; n < 200 && to_cyc.size() < 1; n++) step();
        check("to_seen", to_cyc.size(), 1);
        if (to_cyc.size() == 1 && start_cyc.size() == 1) begin
            check("to_latency", to_cyc[0] - start_cyc[0], 63);
            check("to_start_data", start_data[0], 8'h5C);
        end
        drop_mask = '1;
        for (int n = 0; n < 50 && gnt_ids.size() < 2; n++) step();
        check("to_regrant_count", gnt_ids.size(), 2);
        if (gnt_ids.size() == 2 && to_cyc.size() >= 1) begin
            check("to_regrant_id", gnt_ids[1], 2);
            check("to_regrant_gap", gnt_cyc[1] - to_cyc[0], 17);
        end
        for (int n = 0; n < 100 && to_cyc.size() < 2; n++) step();
        check("to_no_done", done_ids.size(), 0);
        wait_idle("to_idle", 40);
        model_en = 1'b1;

        // Reset while waiting for busy to fall, busy held high across reset
        clear_logs();
        busy_len = 40;
        req = 4'b0001;
        for (int n = 0; n < 50 && gnt_ids.size() < 1; n++) step();
        for (int i = 0; i < 5; i++) step();
        check("rmid_pre_busy", arb_busy, 1);
        force_busy = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("rmid_tx_data", tx_data, 0);
        check("rmid_arb_busy", arb_busy, 0);
        check("rmid_gnt", gnt, 0);
        model_busy = 1'b0;
        model_cnt = 0;
        step();
        rst_n = 1'b1;
        req = 4'b1010;
        for (int i = 0; i < 5; i++) step();
        check("rmid_stall_gnts", gnt_ids.size(), 1);
        check("rmid_stall_idle", arb_busy, 0);
        force_busy = 1'b0;
        step();
        check("rmid_first_gnt", gnt, 4'b0010);
        wait_idle("rmid_idle", 400);

        // Zero-gap instance: two back-to-back requesters
        clear_logs();
        drop_mask_z = '1;
        req_data_z = {8'h00, 8'h00, 8'h22, 8'h11};
        req_z = 4'b0011;
        for (int n = 0; n < 200 && z_start_cyc.size() < 2; n++) step();
        check("z_start_count", z_start_cyc.size(), 2);
        if (z_start_cyc.size() == 2 && z_done_cyc.size() >= 1 && z_gnt_ids.size() == 2) begin
            check("z_spacing", z_start_cyc[1] - z_done_cyc[0], 2);
            check("z_gnt0", z_gnt_ids[0], 0);
            check("z_gnt1", z_gnt_ids[1], 1);
        end
        wait_idle("z_idle", 200);

        check("multi_hot", multi_hot, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
